sobel_window_ctrl: RTL and testbench

Sequencing controller for the Sobel front end. Accepts a raster pixel stream, drives the write side of the two-line FIFO line buffer, and tracks row/column position. It assembles the three buffer taps into a registered 3x3 window with a valid strobe and centre coordinates. Frame start, end and abort are handled here, so the downstream gradient stage sees only fully populated interior windows.

---
 rtl/sobel_window_ctrl_pkg.sv | 19 +
 rtl/window_shift_3x3.sv | 40 ++++
 rtl/sobel_window_ctrl.sv | 127 ++++++++++++
 tb/tb_sobel_window_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_window_ctrl_pkg.sv
// Shared definitions for the Sobel window controller: frame defaults, FSM
// encoding and the 3x3 window byte-index helper.
package sobel_window_ctrl_pkg;

  localparam int WIDTH_DEF  = 640;
  localparam int HEIGHT_DEF = 480;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Byte position of window element (r, c); r=0 is the oldest line, c=0 the oldest column.
  function automatic int win_idx(input int r, input int c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/window_shift_3x3.sv
// Three 3-deep byte shift rows forming the 3x3 window; the newest column
// enters at c=2 from the line-buffer taps (tap2 = oldest line = row 0).
module window_shift_3x3
  import sobel_window_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  tap0_i,
  input  logic [7:0]  tap1_i,
  input  logic [7:0]  tap2_i,
  output logic [71:0] win_o
);

  logic [7:0]  taps [3];
  logic [71:0] win_q, win_d;

  assign taps[0] = tap2_i;
  assign taps[1] = tap1_i;
  assign taps[2] = tap0_i;

  always_comb begin
    win_d = win_q;
    if (en) begin
      for (int r = 0; r < 3; r++) begin
        win_d[8*win_idx(r, 0) +: 8] = win_q[8*win_idx(r, 1) +: 8];
        win_d[8*win_idx(r, 1) +: 8] = win_q[8*win_idx(r, 2) +: 8];
        win_d[8*win_idx(r, 2) +: 8] = taps[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) win_q <= '0;
    else      win_q <= win_d;
  end

  assign win_o = win_q;

endmodule

// File: rtl/sobel_window_ctrl.sv
// Raster sequencing for the Sobel front end: drives the line-buffer write side,
// tracks position, and emits interior 3x3 windows with centre coordinates.
module sobel_window_ctrl
  import sobel_window_ctrl_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int HEIGHT = HEIGHT_DEF,
  parameter int CW     = 10,
  parameter int RW     = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_valid_i,
  input  logic [7:0]    pix_data_i,
  input  logic          sof_i,
  output logic          pix_ready_o,
  output logic          lb_we_o,
  output logic [7:0]    lb_data_o,
  input  logic [7:0]    lb_tap0_i,
  input  logic [7:0]    lb_tap1_i,
  input  logic [7:0]    lb_tap2_i,
  output logic [71:0]   win_o,
  output logic          win_valid_o,
  output logic [RW-1:0] win_row_o,
  output logic [CW-1:0] win_col_o,
  output logic          frame_done_o,
  output logic          frame_err_o
);

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d, cur_col, win_col_q, win_col_d;
  logic [RW-1:0] row_q, row_d, cur_row, win_row_q, win_row_d;
  logic          win_valid_q, win_valid_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          beat, wr;

  assign pix_ready_o = (state_q != DONE);
  assign beat        = pix_valid_i && pix_ready_o;
  assign wr          = beat && (sof_i || state_q == ACTIVE);
  assign lb_we_o     = wr;
  assign lb_data_o   = pix_data_i;

  // A sof beat is always pixel (0,0), whether it starts or aborts a frame.
  assign cur_col = sof_i ? '0 : col_q;
  assign cur_row = sof_i ? '0 : row_q;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    win_valid_d = 1'b0;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE:    if (wr) state_d = ACTIVE;
      ACTIVE:  if (beat && sof_i) err_d = 1'b1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (wr) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
      // Stale lines after an abort or reset are hidden by the row gate.
      if (cur_row >= RW'(2) && cur_col >= CW'(2)) begin
        win_valid_d = 1'b1;
        win_row_d   = cur_row - RW'(1);
        win_col_d   = cur_col - CW'(1);
      end
      if (cur_row == ROW_LAST && cur_col == COL_LAST) begin
        state_d = DONE;
        done_d  = 1'b1;
        col_d   = '0;
        row_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  window_shift_3x3 u_shift (
    .clk    (clk),
    .rst    (rst),
    .en     (wr),
    .tap0_i (lb_tap0_i),
    .tap1_i (lb_tap1_i),
    .tap2_i (lb_tap2_i),
    .win_o  (win_o)
  );

  assign win_valid_o  = win_valid_q;
  assign win_row_o    = win_row_q;
  assign win_col_o    = win_col_q;
  assign frame_done_o = done_q;
  assign frame_err_o  = err_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl: 4x3 frames against a line-buffer model,
// plus a 16x8 instance streaming back-to-back frames.
`timescale 1ns/1ps
module tb_sobel_window_ctrl;
  localparam int W = 4, H = 3;
  localparam int W2 = 16, H2 = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst2 = 1'b0;
  always #5 clk = ~clk;

  // main 4x3 instance
  logic        pix_valid_i = 1'b0, sof_i = 1'b0;
  logic [7:0]  pix_data_i = 8'h00;
  logic        pix_ready_o, lb_we_o, win_valid_o, frame_done_o, frame_err_o;
  logic [7:0]  lb_data_o, tap0, tap1, tap2;
  logic [71:0] win_o;
  logic [1:0]  win_row_o, win_col_o;

  logic [7:0] lb_mem [2*W] = '{default: 8'hEE};
  assign tap0 = lb_data_o;
  assign tap1 = lb_mem[W-1];
  assign tap2 = lb_mem[2*W-1];
  always @(posedge clk)
    if (lb_we_o) begin
      for (int i = 2*W-1; i > 0; i--) lb_mem[i] <= lb_mem[i-1];
      lb_mem[0] <= lb_data_o;
    end

  sobel_window_ctrl #(.WIDTH(W), .HEIGHT(H), .CW(2), .RW(2)) dut (
    .clk(clk), .rst(rst), .pix_valid_i(pix_valid_i), .pix_data_i(pix_data_i),
    .sof_i(sof_i), .pix_ready_o(pix_ready_o), .lb_we_o(lb_we_o), .lb_data_o(lb_data_o),
    .lb_tap0_i(tap0), .lb_tap1_i(tap1), .lb_tap2_i(tap2), .win_o(win_o),
    .win_valid_o(win_valid_o), .win_row_o(win_row_o), .win_col_o(win_col_o),
    .frame_done_o(frame_done_o), .frame_err_o(frame_err_o));

  // second 16x8 instance for back-to-back frames
  logic        v2 = 1'b0, s2 = 1'b0;
  logic [7:0]  d2 = 8'h00;
  logic        ready2, we2, wv2, done2, err2;
  logic [7:0]  ld2, t1_2, t2_2;
  logic [71:0] win2;
  logic [2:0]  row2;
  logic [3:0]  col2;
  logic [7:0]  lb_mem2 [2*W2] = '{default: 8'hEE};
  assign t1_2 = lb_mem2[W2-1];
  assign t2_2 = lb_mem2[2*W2-1];
  always @(posedge clk)
    if (we2) begin
      for (int i = 2*W2-1; i > 0; i--) lb_mem2[i] <= lb_mem2[i-1];
      lb_mem2[0] <= ld2;
    end

  sobel_window_ctrl #(.WIDTH(W2), .HEIGHT(H2), .CW(4), .RW(3)) dut2 (
    .clk(clk), .rst(rst2), .pix_valid_i(v2), .pix_data_i(d2), .sof_i(s2),
    .pix_ready_o(ready2), .lb_we_o(we2), .lb_data_o(ld2), .lb_tap0_i(ld2),
    .lb_tap1_i(t1_2), .lb_tap2_i(t2_2), .win_o(win2), .win_valid_o(wv2),
    .win_row_o(row2), .win_col_o(col2), .frame_done_o(done2), .frame_err_o(err2));

  int strobes2 = 0, dones2 = 0;
  logic inst2_done = 1'b0;
  always @(negedge clk)
    if (rst2) begin
      strobes2 += int'(wv2);
      dones2   += int'(done2);
    end

  initial begin
    logic rdy;
    int   g;
    wait (rst2 == 1'b1);
    @(posedge clk); #1;
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < W2*H2; k++) begin
        v2 = 1'b1; s2 = (k == 0); d2 = 8'(16*(k/W2) + k%W2);
        g = 0;
        do begin
          #4 rdy = ready2;
          @(posedge clk); #1;
          g++;
        end while (!rdy && g < 4);
      end
    v2 = 1'b0; s2 = 1'b0;
    repeat (3) @(posedge clk);
    inst2_done = 1'b1;
  end

  // bench bookkeeping
  int total = 0, bad = 0;
  int strobes, dones, errs, stalls;
  logic last_ready, last_we;

  typedef struct {
    logic v, s; logic [7:0] d;
    logic rdy, we, wv, dn; logic [1:0] r, c; logic [71:0] w;
  } vec_t;
  vec_t tbl [14];

  function automatic logic [7:0] pix(input int k);
    return 8'(16*(k/W) + k%W);
  endfunction

  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[8*(3*i+j) +: 8] = 8'(16*(r-1+i) + (c-1+j));
    return w;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_counts();
    strobes = 0; dones = 0; errs = 0; stalls = 0;
  endtask

  // one clock: drive at posedge+1, sample combinational mid-cycle, registered after edge
  task automatic tick(input logic v, input logic s, input logic [7:0] d);
    pix_valid_i = v; sof_i = s; pix_data_i = d;
    #4;
    last_ready = pix_ready_o;
    last_we    = lb_we_o;
    if (v) chk("lb_data", lb_data_o, d);
    @(posedge clk); #1;
    if (!last_ready) stalls++;
    dones += int'(frame_done_o);
    errs  += int'(frame_err_o);
    if (win_valid_o) begin
      strobes++;
      $display("win row=%0d col=%0d data=%h", win_row_o, win_col_o, win_o);
      chk("strobe_after_write", last_we, 1'b1);
      chk("win_row_interior", win_row_o, 2'd1);
      chk("win_contents", win_o, exp_win(int'(win_row_o), int'(win_col_o)));
    end
  endtask

  task automatic send_frame(input int gap_pct);
    int guard;
    for (int k = 0; k < W*H; k++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) tick(1'b0, 1'b0, 8'hAA);
      guard = 0;
      do begin
        tick(1'b1, k == 0, pix(k));
        guard++;
      end while (!last_ready && guard < 4);
      if (!last_ready) chk("ready_timeout", 1'b0, 1'b1);
    end
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_win_valid"}, win_valid_o, 1'b0);
    chk({tag, "_done"},      frame_done_o, 1'b0);
    chk({tag, "_err"},       frame_err_o, 1'b0);
    chk({tag, "_row"},       win_row_o, 2'd0);
    chk({tag, "_col"},       win_col_o, 2'd0);
    chk({tag, "_win"},       win_o, 72'd0);
    chk({tag, "_ready"},     pix_ready_o, 1'b1);
    chk({tag, "_we"},        lb_we_o, 1'b0);
  endtask

  initial begin
    // clean 4x3 frame: 12 beats, a valid sof held off by DONE, then idle
    for (int k = 0; k < 12; k++)
      tbl[k] = '{1'b1, (k == 0), pix(k), 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 72'd0};
    tbl[10].wv = 1'b1; tbl[10].r = 2'd1; tbl[10].c = 2'd1; tbl[10].w = 72'h22_21_20_12_11_10_02_01_00;
    tbl[11].wv = 1'b1; tbl[11].r = 2'd1; tbl[11].c = 2'd2; tbl[11].w = 72'h23_22_21_13_12_11_03_02_01;
    tbl[11].dn = 1'b1;
    tbl[12] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 72'd0};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 72'd0};

    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset");
    @(negedge clk); rst = 1'b1; rst2 = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      pix_valid_i = tbl[i].v; sof_i = tbl[i].s; pix_data_i = tbl[i].d;
      #4;
      chk($sformatf("tbl%0d_ready", i), pix_ready_o, tbl[i].rdy);
      chk($sformatf("tbl%0d_we", i), lb_we_o, tbl[i].we);
      @(posedge clk); #1;
      $display("vec %0d wv=%0b row=%0d col=%0d done=%0b", i, win_valid_o, win_row_o, win_col_o, frame_done_o);
      chk($sformatf("tbl%0d_wv", i), win_valid_o, tbl[i].wv);
      chk($sformatf("tbl%0d_done", i), frame_done_o, tbl[i].dn);
      chk($sformatf("tbl%0d_err", i), frame_err_o, 1'b0);
      chk($sformatf("tbl%0d_row", i), win_row_o, tbl[i].r);
      chk($sformatf("tbl%0d_col", i), win_col_o, tbl[i].c);
      if (tbl[i].wv) chk($sformatf("tbl%0d_win", i), win_o, tbl[i].w);
    end

    // pixels without sof in IDLE are dropped, then a normal frame
    clr_counts();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, 8'h77);
      chk("idle_no_write", last_we, 1'b0);
    end
    chk("idle_no_strobe", strobes, 0);
    send_frame(0);
    chk("clean_strobes", strobes, 2);
    chk("clean_done", dones, 1);
    chk("clean_stall", stalls, 1);
    chk("clean_err", errs, 0);

    // random valid gaps
    clr_counts();
    send_frame(40);
    chk("gaps_strobes", strobes, 2);
    chk("gaps_done", dones, 1);
    chk("gaps_err", errs, 0);

    // abort at (1,2), then the aborting pixel starts a full frame
    clr_counts();
    for (int k = 0; k < 6; k++) tick(1'b1, k == 0, pix(k));
    send_frame(0);
    chk("abort_err", errs, 1);
    chk("abort_strobes", strobes, 2);
    chk("abort_done", dones, 1);

    // sof on the would-be last pixel is an abort, not a completion
    clr_counts();
    for (int k = 0; k < 11; k++) tick(1'b1, k == 0, pix(k));
    chk("lastabort_pre_done", dones, 0);
    send_frame(0);
    chk("lastabort_err", errs, 1);
    chk("lastabort_strobes", strobes, 3);
    chk("lastabort_done", dones, 1);

    // asynchronous reset in the middle of the cycle presenting (2,1)
    clr_counts();
    for (int k = 0; k < 9; k++) tick(1'b1, k == 0, pix(k));
    pix_valid_i = 1'b1; sof_i = 1'b0; pix_data_i = pix(9);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("midreset");
    @(negedge clk); pix_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    clr_counts();
    send_frame(0);
    chk("postreset_strobes", strobes, 2);
    chk("postreset_done", dones, 1);
    chk("postreset_err", errs, 0);

    // back-to-back 16x8 frames: 14*6 interior windows per frame
    for (int i = 0; i < 3000 && !inst2_done; i++) @(posedge clk);
    chk("b2b_finished", inst2_done, 1'b1);
    chk("b2b_strobes", strobes2, 2*(W2-2)*(H2-2));
    chk("b2b_done", dones2, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
